// File: rtl/rrp_otf_conv_pkg.sv
// Shared digit-width rules for the radix-r signed-digit datapath.
// Exports K/D derivation, illegal-digit pattern and converter state enum.
package rrp_otf_conv_pkg;

  function automatic int digit_k(input int radix);
    return $clog2(radix);
  endfunction

  function automatic int digit_d(input int radix);
    return $clog2(radix) + 1;
  endfunction

  // -r in D-bit two's complement is a 1 followed by K zeros,
  // which is the same bit pattern as +r; callers truncate to D bits.
  function automatic logic [31:0] illegal_digit(input int radix);
    return 32'(radix);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

endpackage

// File: rtl/rrp_otf_conv_if.sv
// Handshake bundle between multiplier, converter and binary consumer.
// Ports: p_in/in_valid/in_ready (input side), result/out_err/out_valid/out_ready.
interface rrp_otf_conv_if
  import rrp_otf_conv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int RADIX = 4
);
  localparam int K    = digit_k(RADIX);
  localparam int D    = K + 1;
  localparam int NDIG = 2 * WIDTH + 1;
  localparam int BW   = K * NDIG + 1;

  logic [D*NDIG-1:0] p_in;
  logic              in_valid;
  logic              in_ready;
  logic [BW-1:0]     result;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output p_in, in_valid, out_ready,
    input  in_ready, result, out_err, out_valid
  );

  modport slave (
    input  p_in, in_valid, out_ready,
    output in_ready, result, out_err, out_valid
  );

endinterface

// File: rtl/rrp_otf_conv_otf_step.sv
// Combinational one-digit on-the-fly conversion step (Q/QM append).
// Ports: q_i/qm_i kept bits, d_i signed digit; qn_o/qmn_o next, bad_o = digit -r.
module rrp_otf_conv_otf_step
  import rrp_otf_conv_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int W     = 6
) (
  input  logic [W-1:0]                q_i,
  input  logic [W-1:0]                qm_i,
  input  logic [digit_d(RADIX)-1:0]   d_i,
  output logic [W+digit_k(RADIX)-1:0] qn_o,
  output logic [W-1:0]                qmn_o,
  output logic                        bad_o
);

  localparam int K = digit_k(RADIX);
  localparam int D = K + 1;
  localparam logic [D-1:0] BAD = D'(illegal_digit(RADIX));

  logic         neg;
  logic         pos;
  logic [K-1:0] dm1;

  assign neg = d_i[D-1];
  assign pos = ~neg & (|d_i[K-1:0]);
  // r+d and r-1+d share their low K bits with d and d-1.
  assign dm1 = d_i[K-1:0] - K'(1);

  assign qn_o  = neg ? {qm_i, d_i[K-1:0]}
                     : {q_i, d_i[K-1:0]};
  assign qmn_o = pos ? W'({q_i, dm1})
                     : W'({qm_i, dm1});
  assign bad_o = (d_i == BAD);

endmodule

// File: rtl/rrp_otf_conv.sv
// Digit-serial MSD-first signed-digit to two's-complement converter.
// Ports: clock, reset (async high), bus (slave: p_in/in_valid/in_ready, result/out_err/out_valid/out_ready).
module rrp_otf_conv
  import rrp_otf_conv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int RADIX = 4
) (
  input  logic           clock,
  input  logic           reset,
  rrp_otf_conv_if.slave  bus
);

  localparam int K    = digit_k(RADIX);
  localparam int D    = K + 1;
  localparam int NDIG = 2 * WIDTH + 1;
  localparam int BW   = K * NDIG + 1;
  localparam int SW   = D * NDIG;
  // Only the low BW-K bits of Q/QM survive the next append.
  localparam int W    = BW - K;
  localparam int CW   = $clog2(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  qm_q, qm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [BW-1:0] res_q, res_d;
  logic          oerr_q, oerr_d;

  logic [D-1:0]  dig;
  logic [BW-1:0] qn;
  logic [W-1:0]  qmn;
  logic          bad;

  assign dig = sh_q[SW-1 -: D];

  rrp_otf_conv_otf_step #(
    .RADIX (RADIX),
    .W     (W)
  ) u_step (
    .q_i   (q_q),
    .qm_i  (qm_q),
    .d_i   (dig),
    .qn_o  (qn),
    .qmn_o (qmn),
    .bad_o (bad)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      q_q     <= '0;
      qm_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res_q   <= res_d;
      oerr_q  <= oerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    res_d   = res_q;
    oerr_d  = oerr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sh_d    = bus.p_in;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d  = {sh_q[SW-D-1:0], D'(0)};
        q_d   = qn[W-1:0];
        qm_d  = qmn;
        cnt_d = cnt_q + CW'(1);
        err_d = err_q | bad;
        if (cnt_q == LAST) begin
          res_d   = qn;
          oerr_d  = err_q | bad;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) & ~reset;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.out_err   = oerr_q;

endmodule

// File: tb/tb_rrp_otf_conv.sv
// Directed bench for rrp_otf_conv at WIDTH=1, RADIX=4 (NDIG=3, BW=7).
// Hand-computed digit words, latency, backpressure and reset abort.
module tb_rrp_otf_conv;

  localparam int WIDTH = 1;
  localparam int RADIX = 4;
  localparam int NDIG  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   n;

  rrp_otf_conv_if #(.WIDTH(WIDTH), .RADIX(RADIX)) bus ();

  rrp_otf_conv #(
    .WIDTH (WIDTH),
    .RADIX (RADIX)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_word(input logic [8:0] p, input logic [6:0] exp_r,
                          input logic exp_e, input string tag);
    int c;
    chk({tag, "/in_ready"}, 32'(bus.in_ready), 1);
    bus.p_in     = p;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk({tag, "/busy"}, 32'(bus.in_ready), 0);
    wait_out(c);
    chk({tag, "/latency"}, 32'(c), NDIG);
    chk({tag, "/result"}, 32'(bus.result), 32'(exp_r));
    chk({tag, "/err"}, 32'(bus.out_err), 32'(exp_e));
    step();
    chk({tag, "/vld_drop"}, 32'(bus.out_valid), 0);
    chk({tag, "/ready_back"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    bus.p_in      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst/in_ready", 32'(bus.in_ready), 0);
    chk("rst/out_valid", 32'(bus.out_valid), 0);
    chk("rst/result", 32'(bus.result), 0);
    chk("rst/out_err", 32'(bus.out_err), 0);
    reset = 1'b0;
    step();
    chk("rel/in_ready", 32'(bus.in_ready), 1);

    // abort mid-conversion
    bus.p_in     = 9'h0BB;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("abort/busy", 32'(bus.in_ready), 0);
    reset = 1'b1;
    #1;
    chk("abort/in_ready_rst", 32'(bus.in_ready), 0);
    chk("abort/out_valid_rst", 32'(bus.out_valid), 0);
    step();
    reset = 1'b0;
    step();
    chk("abort/in_ready", 32'(bus.in_ready), 1);
    chk("abort/out_valid", 32'(bus.out_valid), 0);
    chk("abort/result", 32'(bus.result), 0);
    step();
    step();
    step();
    chk("abort/no_valid", 32'(bus.out_valid), 0);

    run_word(9'h0BB, 7'h1F, 1'b0, "w_2_m1_3");
    run_word(9'h147, 7'h4F, 1'b0, "w_m3_0_m1");
    run_word(9'h0DB, 7'h3F, 1'b0, "w_max");
    run_word(9'h16D, 7'h41, 1'b0, "w_min");
    run_word(9'h100, 7'h40, 1'b1, "w_illegal");
    run_word(9'h0BB, 7'h1F, 1'b0, "w_err_clear");

    // backpressure: hold result, ignore a new word while busy
    bus.out_ready = 1'b0;
    bus.p_in      = 9'h0DB;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    wait_out(n);
    chk("bp/latency", 32'(n), NDIG);
    chk("bp/result", 32'(bus.result), 32'h3F);
    bus.p_in     = 9'h16D;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp/hold_result", 32'(bus.result), 32'h3F);
      chk("bp/hold_valid", 32'(bus.out_valid), 1);
      chk("bp/hold_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp/release_valid", 32'(bus.out_valid), 0);
    chk("bp/release_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    chk("bp/accepted", 32'(bus.in_ready), 0);
    wait_out(n);
    chk("bp/2nd_latency", 32'(n), NDIG);
    chk("bp/2nd_result", 32'(bus.result), 32'h41);
    chk("bp/2nd_err", 32'(bus.out_err), 0);
    step();
    chk("bp/2nd_drop", 32'(bus.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
